// File: rtl/regfile_arbiter.sv
// Purpose : shares one single-port 8x16 register file between requester 0 (core) and
//           requester 1 (debug/load). Serialises each request into a write or read cycle,
//           captures the registered read data, and pulses done to the owner.
// Latency : write = done 2 cycles after the IDLE sample cycle, read = 3 cycles.
// Backpressure: requests are sampled only in IDLE. A requester holds req and its command
//           until it sees done. Requests arriving while busy wait.
// Ports   : clock_i/reset_i (async active-high); req_*_i per-requester command, packed {r1,r0};
//           gnt_o/done_o owner handshake; rdata_s_o/rdata_t_o captured read data;
//           busy_o; rf_*_o drive the register file; rf_rs_data_i/rf_rt_data_i its read data.
// Config  : `define RF_ARB_ROUND_ROBIN_EN -> ties go to the requester that was not the last owner.
//           Without the macro, requester 0 always wins a tie.
module regfile_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [1:0]            req_i,
    input  logic [1:0]            req_we_i,
    input  logic [2*ADDR_W-1:0]   req_rs_addr_i,
    input  logic [2*ADDR_W-1:0]   req_rt_addr_i,
    input  logic [2*ADDR_W-1:0]   req_rd_addr_i,
    input  logic [2*DATA_W-1:0]   req_wdata_i,
    output logic [1:0]            gnt_o,
    output logic [1:0]            done_o,
    output logic [DATA_W-1:0]     rdata_s_o,
    output logic [DATA_W-1:0]     rdata_t_o,
    output logic                  busy_o,
    output logic                  rf_reset_o,
    output logic                  rf_write_o,
    output logic [ADDR_W-1:0]     rf_rs_addr_o,
    output logic [ADDR_W-1:0]     rf_rt_addr_o,
    output logic [ADDR_W-1:0]     rf_rd_addr_o,
    output logic [DATA_W-1:0]     rf_data_o,
    input  logic [DATA_W-1:0]     rf_rs_data_i,
    input  logic [DATA_W-1:0]     rf_rt_data_i
);

    typedef enum logic [2:0] {
        S_CLEAR   = 3'd0,
        S_IDLE    = 3'd1,
        S_WRITE   = 3'd2,
        S_READ    = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        gnt_q, gnt_d;
    logic [ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_s_q, rdata_s_d, rdata_t_q, rdata_t_d;

    logic win;      // index of the winning requester
    logic accept;   // a transaction starts this cycle
    logic sel_we;

    assign accept = (state_q == S_IDLE) && (req_i != 2'b00);

`ifdef RF_ARB_ROUND_ROBIN_EN
    logic last_q;   // last owner; reset to 1 so requester 0 wins the first tie

    always_comb begin
        if (req_i == 2'b11) win = ~last_q;
        else                win = ~req_i[0];
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)     last_q <= 1'b1;
        else if (accept) last_q <= win;
    end
`else
    // Fixed priority: requester 0 wins whenever it is requesting.
    assign win = ~req_i[0];
`endif

    assign sel_we = win ? req_we_i[1] : req_we_i[0];

    // ---------------- state register ----------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state_q <= S_CLEAR;
        else         state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_CLEAR:   state_d = S_IDLE;
            S_IDLE:    if (accept) state_d = sel_we ? S_WRITE : S_READ;
            S_WRITE:   state_d = S_DONE;
            S_READ:    state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_CLEAR;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        busy_o     = (state_q != S_IDLE);
        rf_reset_o = (state_q == S_CLEAR);
        rf_write_o = (state_q == S_WRITE);
        done_o     = (state_q == S_DONE) ? gnt_q : 2'b00;
    end

    // ---------------- command / capture registers ----------------
    always_comb begin
        gnt_d     = gnt_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        wdata_d   = wdata_q;
        rdata_s_d = rdata_s_q;
        rdata_t_d = rdata_t_q;
        if (accept) begin
            gnt_d   = win ? 2'b10 : 2'b01;
            rs_d    = win ? req_rs_addr_i[2*ADDR_W-1:ADDR_W] : req_rs_addr_i[ADDR_W-1:0];
            rt_d    = win ? req_rt_addr_i[2*ADDR_W-1:ADDR_W] : req_rt_addr_i[ADDR_W-1:0];
            rd_d    = win ? req_rd_addr_i[2*ADDR_W-1:ADDR_W] : req_rd_addr_i[ADDR_W-1:0];
            wdata_d = win ? req_wdata_i[2*DATA_W-1:DATA_W]   : req_wdata_i[DATA_W-1:0];
        end
        if (state_q == S_DONE) gnt_d = 2'b00;
        // The register file's read outputs are registered, so data for the
        // READ-cycle addresses is only valid one cycle later, in CAPTURE.
        if (state_q == S_CAPTURE) begin
            rdata_s_d = rf_rs_data_i;
            rdata_t_d = rf_rt_data_i;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            gnt_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            wdata_q   <= '0;
            rdata_s_q <= '0;
            rdata_t_q <= '0;
        end else begin
            gnt_q     <= gnt_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            wdata_q   <= wdata_d;
            rdata_s_q <= rdata_s_d;
            rdata_t_q <= rdata_t_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign rdata_s_o    = rdata_s_q;
    assign rdata_t_o    = rdata_t_q;
    assign rf_rs_addr_o = rs_q;
    assign rf_rt_addr_o = rt_q;
    assign rf_rd_addr_o = rd_q;
    assign rf_data_o    = wdata_q;

endmodule
